// File: rtl/pr_timer_bank.sv
// rtl/pr_timer_bank.sv - bank of NUM_CH down-counting timers on the processor peripheral bus
// Optional per-channel prescaler enabled by defining TIMER_PRESCALE_EN.
module pr_timer_bank #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel,
   input  logic [29:0]       PrAddr,
   input  logic [3:0]        PrBE,
   input  logic [31:0]       PrWD,
   input  logic              PrWe,
   output logic [31:0]       PrRD,
   output logic [NUM_CH-1:0] irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2
   } chState_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [2:0]  chIdx;
   logic [1:0]  regIdx;
   logic        wrEn;
   logic [31:0] beMask;

   assign chIdx  = PrAddr[4:2];
   assign regIdx = PrAddr[1:0];
   assign wrEn   = sel & PrWe;
   assign beMask = {{8{PrBE[3]}}, {8{PrBE[2]}}, {8{PrBE[1]}}, {8{PrBE[0]}}};

   chState_t          state      [NUM_CH];
   logic [WIDTH-1:0]  preset     [NUM_CH];
   logic [WIDTH-1:0]  count      [NUM_CH];
   logic [WIDTH-1:0]  presetNext [NUM_CH];
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] im;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] ctrlWr;
   logic [NUM_CH-1:0] presetWr;
   logic [NUM_CH-1:0] tick;

`ifdef TIMER_PRESCALE_EN
   logic [7:0]        prescale [NUM_CH];
   logic [7:0]        psLive   [NUM_CH];
   logic [7:0]        psCnt    [NUM_CH];
   logic [NUM_CH-1:0] psWr;
`endif

   // PRESET of zero would never expire, so it behaves as one
   function automatic logic [WIDTH-1:0] reloadVal(input logic [WIDTH-1:0] p);
      return (p == '0) ? ONE : p;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ctrlWr[i]     = wrEn && (chIdx == 3'(i)) && (regIdx == 2'd0);
         presetWr[i]   = wrEn && (chIdx == 3'(i)) && (regIdx == 2'd1);
         presetNext[i] = WIDTH'((PrWD & beMask) | (32'(preset[i]) & ~beMask));
`ifdef TIMER_PRESCALE_EN
         psWr[i]       = wrEn && (chIdx == 3'(i)) && (regIdx == 2'd3) && PrBE[0];
         tick[i]       = (psCnt[i] == 8'd0);
`else
         tick[i]       = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i]  <= IDLE;
            preset[i] <= '0;
            count[i]  <= '0;
            en[i]     <= 1'b0;
            mode[i]   <= 1'b0;
            im[i]     <= 1'b0;
            pend[i]   <= 1'b0;
            irq[i]    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale[i] <= 8'd0;
            psLive[i]   <= 8'd0;
            psCnt[i]    <= 8'd0;
`endif
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            irq[i] <= pend[i] & im[i];
            if (presetWr[i])
               preset[i] <= presetNext[i];
`ifdef TIMER_PRESCALE_EN
            if (psWr[i])
               prescale[i] <= PrWD[7:0];
`endif
            // A CTRL write overrides whatever the FSM would do this cycle, expiry included
            if (ctrlWr[i]) begin
               if (PrBE[0]) begin
                  en[i]   <= PrWD[0];
                  mode[i] <= PrWD[1];
                  im[i]   <= PrWD[3];
               end
               pend[i]  <= 1'b0;
               state[i] <= (PrBE[0] ? PrWD[0] : en[i]) ? LOAD : IDLE;
            end else begin
               case (state[i])
                  IDLE: begin
                     if (en[i])
                        state[i] <= LOAD;
                  end
                  LOAD: begin
                     count[i] <= reloadVal(preset[i]);
                     state[i] <= CNT;
`ifdef TIMER_PRESCALE_EN
                     psLive[i] <= prescale[i];
                     psCnt[i]  <= prescale[i];
`endif
                  end
                  CNT: begin
`ifdef TIMER_PRESCALE_EN
                     psCnt[i] <= tick[i] ? psLive[i] : psCnt[i] - 8'd1;
`endif
                     if (tick[i]) begin
                        if (count[i] == ONE) begin
                           pend[i] <= 1'b1;
                           if (mode[i]) begin
                              count[i] <= reloadVal(preset[i]);
                           end else begin
                              count[i] <= '0;
                              en[i]    <= 1'b0;
                              state[i] <= IDLE;
                           end
                        end else begin
                           count[i] <= count[i] - ONE;
                        end
                     end
                  end
                  default: state[i] <= IDLE;
               endcase
            end
         end
      end
   end

   always_comb begin
      PrRD = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel && (chIdx == 3'(i))) begin
            case (regIdx)
               2'd0: PrRD = {27'd0, pend[i], im[i], 1'b0, mode[i], en[i]};
               2'd1: PrRD = 32'(preset[i]);
               2'd2: PrRD = 32'(count[i]);
`ifdef TIMER_PRESCALE_EN
               default: PrRD = {24'd0, prescale[i]};
`else
               default: PrRD = 32'd0;
`endif
            endcase
         end
      end
   end

endmodule
